al422_frame_writer: RTL

Write-side loader for the AL422 frame FIFO. It accepts a byte stream of pixel data with a start-of-frame marker, resets the AL422 write pointer at every frame start, and drives the AL422 write strobe and data bus for exactly one frame's worth of bytes. It sits directly upstream of the AL422, which the BAM read/scan path consumes. It reports completed and malformed frames to the host side.

---
 rtl/al422_frame_writer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/al422_frame_writer.sv
// AL422 write-side frame loader: turns an SOF-marked byte stream into
// write-pointer reset pulses and one frame's worth of write strobes,
// reporting completed and malformed frames.
`timescale 1ns/1ps
module al422_frame_writer #(
  parameter int PIXEL_COUNT     = 64,
  parameter int BYTES_PER_PIXEL = 3,
  parameter int WRST_CYCLES     = 2
) (
  input  logic       in_clk,
  input  logic       in_nrst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_sof,
  output logic       in_ready,
  output logic [7:0] al422_data,
  output logic       al422_we_n,
  output logic       al422_wrst_n,
  output logic       frame_done,
  output logic       frame_err,
  output logic [7:0] frame_count
);

  localparam int FRAME_BYTES = PIXEL_COUNT * BYTES_PER_PIXEL;
  localparam int CNT_W       = $clog2(FRAME_BYTES + 1);
  localparam int WR_W        = $clog2(WRST_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BYTES);
  localparam logic [WR_W-1:0]  WR_LAST  = WR_W'(WRST_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRST  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic [WR_W-1:0]  wr_cnt, wr_cnt_nx;
  logic [7:0]       hold, hold_nx;
  logic [7:0]       data_nx;
  logic             we_n_nx, wrst_n_nx, done_nx, err_nx;
  logic [7:0]       count_nx;
  logic             accept;

  // The block stalls the stream only while the write pointer is being reset.
  assign in_ready = (state != WRST);
  assign accept   = in_valid & in_ready;
  assign cnt_inc  = cnt + CNT_W'(1);

  // Next-state and next-output decode; every AL422-side output is registered.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    wr_cnt_nx = wr_cnt;
    hold_nx   = hold;
    data_nx   = al422_data;
    we_n_nx   = 1'b1;
    wrst_n_nx = 1'b1;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    count_nx  = frame_count;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_sof) begin
            hold_nx   = in_data;
            state_nx  = WRST;
            wrst_n_nx = 1'b0;
            wr_cnt_nx = WR_W'(1);
            cnt_nx    = '0;
          end else begin
            // Stray byte outside a frame: dropped, flagged.
            err_nx = 1'b1;
          end
        end
      end
      WRST: begin
        if (wr_cnt == WR_LAST) begin
          // Pointer reset finished: write the SOF byte held during the gap.
          we_n_nx = 1'b0;
          data_nx = hold;
          cnt_nx  = CNT_W'(1);
          if (FRAME_BYTES == 1) begin
            done_nx  = 1'b1;
            count_nx = frame_count + 8'd1;
            state_nx = IDLE;
          end else begin
            state_nx = WRITE;
          end
        end else begin
          wr_cnt_nx = wr_cnt + WR_W'(1);
          wrst_n_nx = 1'b0;
        end
      end
      WRITE: begin
        if (accept) begin
          if (in_sof) begin
            // Short frame: restart; the pointer reset discards the partial frame.
            err_nx    = 1'b1;
            hold_nx   = in_data;
            state_nx  = WRST;
            wrst_n_nx = 1'b0;
            wr_cnt_nx = WR_W'(1);
            cnt_nx    = '0;
          end else begin
            we_n_nx = 1'b0;
            data_nx = in_data;
            cnt_nx  = cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              done_nx  = 1'b1;
              count_nx = frame_count + 8'd1;
              state_nx = IDLE;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, counters and registered outputs with asynchronous active-low reset.
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      state        <= IDLE;
      cnt          <= '0;
      wr_cnt       <= '0;
      hold         <= '0;
      al422_data   <= '0;
      al422_we_n   <= 1'b1;
      al422_wrst_n <= 1'b1;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
      frame_count  <= '0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      wr_cnt       <= wr_cnt_nx;
      hold         <= hold_nx;
      al422_data   <= data_nx;
      al422_we_n   <= we_n_nx;
      al422_wrst_n <= wrst_n_nx;
      frame_done   <= done_nx;
      frame_err    <= err_nx;
      frame_count  <= count_nx;
    end
  end

endmodule
